usb_tx_framer: RTL

Transmit-side framer that sits directly upstream of the FT245 synchronous FIFO interface. It buffers payload bytes from fabric logic, wraps each packet as SYNC + payload + XOR checksum, and feeds the FT245 controller's `data_to_pc` / `_write_data` inputs. It advances one byte for each FT245 write transfer it observes on `_txe`/`_wr`.

---
 rtl/usb_pkg.sv | 18 +
 rtl/byte_fifo.sv | 60 ++++++
 rtl/usb_tx_framer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// Shared types and defaults for the USB/FT245 transmit path.
package usb_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } tx_state_t;

  // Running frame checksum: plain XOR over the payload bytes.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with occupancy count; head entry is visible on rd_data without a pop.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_push_s = push && (count_r != CNT_FULL);
  assign do_pop_s  = pop && (count_r != '0);
  assign rd_data   = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/usb_tx_framer.sv
// Wraps buffered payload as SYNC + payload + XOR checksum and paces it by FT245 write transfers.
module usb_tx_framer
  import usb_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter int         AW        = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready,
  input  logic        _txe,
  input  logic        _wr,
  output logic        _write_data,
  output logic [7:0]  data_to_pc,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PEND_ONE = (AW+1)'(1);

  tx_state_t   state_r;
  tx_state_t   state_nxt_s;
  logic [7:0]  csum_r;
  logic [7:0]  csum_nxt_s;
  logic [AW:0] pending_r;
  logic [15:0] frames_sent_r;
  logic [8:0]  head_s;
  logic [AW:0] fifo_count_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        push_s;
  logic        pop_s;
  logic        frame_done_s;
  logic        xfer_s;
  logic        write_n_s;
  logic [7:0]  data_s;

  assign fifo_full_s  = (fifo_count_s == CNT_FULL);
  assign fifo_empty_s = (fifo_count_s == '0);
  assign tx_ready     = !fifo_full_s;
  assign push_s       = tx_valid && tx_ready;
  assign xfer_s       = !_wr && !_txe;

  byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (9)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (_reset),
    .push    (push_s),
    .wr_data ({tx_last, tx_data}),
    .pop     (pop_s),
    .rd_data (head_s),
    .count   (fifo_count_s)
  );

  // Next-state, pop and output decode; outputs depend on registered state only.
  always_comb begin
    state_nxt_s  = state_r;
    csum_nxt_s   = csum_r;
    pop_s        = 1'b0;
    frame_done_s = 1'b0;
    write_n_s    = 1'b1;
    data_s       = 8'h00;
    case (state_r)
      IDLE: begin
        // A full FIFO with no complete frame starts a cut-through frame.
        if ((pending_r != '0) || fifo_full_s) begin
          state_nxt_s = SYNC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SYNC: begin
        csum_nxt_s = 8'h00;
        write_n_s  = 1'b0;
        data_s     = SYNC_BYTE;
        if (xfer_s) begin
          state_nxt_s = PAYLOAD;
        end else begin
          state_nxt_s = SYNC;
        end
      end
      PAYLOAD: begin
        data_s = head_s[7:0];
        if (!fifo_empty_s) begin
          write_n_s = 1'b0;
          if (xfer_s) begin
            pop_s      = 1'b1;
            csum_nxt_s = csum_step(csum_r, head_s[7:0]);
            if (head_s[8]) begin
              state_nxt_s = CSUM;
            end else begin
              state_nxt_s = PAYLOAD;
            end
          end else begin
            state_nxt_s = PAYLOAD;
          end
        end else begin
          write_n_s = 1'b1;
        end
      end
      CSUM: begin
        write_n_s = 1'b0;
        data_s    = csum_r;
        if (xfer_s) begin
          frame_done_s = 1'b1;
          state_nxt_s  = IDLE;
        end else begin
          state_nxt_s = CSUM;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, checksum, pending-frame and frame counters.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_r       <= IDLE;
      csum_r        <= 8'h00;
      pending_r     <= '0;
      frames_sent_r <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      csum_r  <= csum_nxt_s;
      case ({push_s && tx_last, pop_s && head_s[8]})
        2'b10:   pending_r <= pending_r + PEND_ONE;
        2'b01:   pending_r <= pending_r - PEND_ONE;
        default: pending_r <= pending_r;
      endcase
      if (frame_done_s) begin
        frames_sent_r <= frames_sent_r + 16'd1;
      end
    end
  end

  assign _write_data = write_n_s;
  assign data_to_pc  = data_s;
  assign busy        = (state_r != IDLE);
  assign frames_sent = frames_sent_r;

endmodule
